// File: rtl/sd_cmd_phy.sv
// SD CMD line PHY: serialises a 48-bit command with CRC7, then captures the 48-bit card response.
// Optional receive CRC7 check is built when SD_CMD_RESP_CRC_CHECK_EN is defined.
module sd_cmd_phy #(
   parameter int PARAM_TIMEOUT_BITS = 64,
   parameter int PARAM_CNT_W        = 7
) (
   input  logic        iClock_host,
   input  logic        iReset,
   input  logic        iBit_en,
   input  logic        iStrobe_in,
   input  logic [47:0] iCmd_in,
   input  logic        iAck_in,
   input  logic        iCmd_pin,
   output logic        oCmd_pin,
   output logic        oCmd_oe,
   output logic        oStrobe_out,
   output logic        oAck_out,
   output logic [47:0] oResponse,
   output logic        oTimeout,
   output logic        oBusy,
   output logic        oCrc_error
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RECV = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [PARAM_CNT_W-1:0] CNT_PAYLOAD = PARAM_CNT_W'(40);
   localparam logic [PARAM_CNT_W-1:0] CNT_ENDBIT  = PARAM_CNT_W'(47);
   localparam logic [PARAM_CNT_W-1:0] CNT_RXLAST  = PARAM_CNT_W'(46);
   localparam logic [PARAM_CNT_W-1:0] CNT_RXCRC   = PARAM_CNT_W'(39);
   localparam logic [PARAM_CNT_W-1:0] CNT_TMO     = PARAM_CNT_W'(PARAM_TIMEOUT_BITS - 1);

   logic [2:0]             state_q, state_d;
   logic [PARAM_CNT_W-1:0] cnt_q, cnt_d;
   logic [47:0]            tx_sh_q, tx_sh_d;
   logic [46:0]            rx_sh_q, rx_sh_d;
   logic [6:0]             crc_q, crc_d;
   logic                   strb_prev_q;
   logic                   pin_q, pin_d;
   logic                   oe_q, oe_d;
   logic                   strobe_q, strobe_d;
   logic                   ack_q, ack_d;
   logic [47:0]            resp_q, resp_d;
   logic                   tmo_q, tmo_d;
   logic                   busy_q;
   logic                   accept;
   logic                   rx_last;
   logic                   unused_cmd_bits;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // CRC field bits of the command are regenerated, never transmitted
   assign unused_cmd_bits = ^iCmd_in[7:1];

   assign accept  = (state_q == S_IDLE) && iStrobe_in && !strb_prev_q;
   assign rx_last = (state_q == S_RECV) && iBit_en && (cnt_q == CNT_RXLAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_sh_d  = tx_sh_q;
      rx_sh_d  = rx_sh_q;
      crc_d    = crc_q;
      pin_d    = pin_q;
      oe_d     = oe_q;
      strobe_d = strobe_q;
      ack_d    = 1'b0;
      resp_d   = resp_q;
      tmo_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ack_d   = 1'b1;
               tx_sh_d = {iCmd_in[47:8], 7'd0, iCmd_in[0]};
               cnt_d   = '0;
               crc_d   = '0;
               oe_d    = 1'b1;
               pin_d   = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (iBit_en) begin
               if (cnt_q < CNT_PAYLOAD) begin
                  pin_d   = tx_sh_q[47];
                  crc_d   = crc7_step(crc_q, tx_sh_q[47]);
                  tx_sh_d = {tx_sh_q[46:0], 1'b0};
                  cnt_d   = cnt_q + 1'b1;
               end else if (cnt_q < CNT_ENDBIT) begin
                  pin_d = crc_q[6];
                  crc_d = {crc_q[5:0], 1'b0};
                  cnt_d = cnt_q + 1'b1;
               end else if (cnt_q == CNT_ENDBIT) begin
                  pin_d = 1'b1;
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  pin_d   = 1'b1;
                  oe_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (iBit_en) begin
               if (!iCmd_pin) begin
                  rx_sh_d = {rx_sh_q[45:0], 1'b0};
                  cnt_d   = '0;
                  crc_d   = '0;
                  state_d = S_RECV;
               end else if (cnt_q == CNT_TMO) begin
                  tmo_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RECV: begin
            if (iBit_en) begin
               rx_sh_d = {rx_sh_q[45:0], iCmd_pin};
               cnt_d   = cnt_q + 1'b1;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
               if (cnt_q < CNT_RXCRC) crc_d = crc7_step(crc_q, iCmd_pin);
`endif
               if (cnt_q == CNT_RXLAST) begin
                  resp_d   = {rx_sh_q, iCmd_pin};
                  strobe_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (iAck_in) begin
               strobe_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClock_host) begin
      if (iReset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         strb_prev_q <= 1'b0;
         pin_q       <= 1'b1;
         oe_q        <= 1'b0;
         strobe_q    <= 1'b0;
         ack_q       <= 1'b0;
         resp_q      <= '0;
         tmo_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         strb_prev_q <= iStrobe_in;
         pin_q       <= pin_d;
         oe_q        <= oe_d;
         strobe_q    <= strobe_d;
         ack_q       <= ack_d;
         resp_q      <= resp_d;
         tmo_q       <= tmo_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   // Shift/CRC datapath needs no reset: it is reloaded on every accept or start bit
   always_ff @(posedge iClock_host) begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      crc_q   <= crc_d;
   end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
   logic crc_err_q;
   always_ff @(posedge iClock_host) begin
      if (iReset || accept) crc_err_q <= 1'b0;
      else if (rx_last && (crc_q != rx_sh_q[6:0])) crc_err_q <= 1'b1;
   end
   assign oCrc_error = crc_err_q;
`else
   assign oCrc_error = 1'b0;
`endif

   assign oCmd_pin    = pin_q;
   assign oCmd_oe     = oe_q;
   assign oStrobe_out = strobe_q;
   assign oAck_out    = ack_q;
   assign oResponse   = resp_q;
   assign oTimeout    = tmo_q;
   assign oBusy       = busy_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: CMD0/CMD8 framing, response capture, timeout, strobe edge rule,
// stalled bit clock, mid-frame reset and (build dependent) response CRC error.
module tb_sd_cmd_phy;
   logic        clk = 1'b0;
   logic        iReset = 1'b1;
   logic        iBit_en = 1'b1;
   logic        iStrobe_in = 1'b0;
   logic [47:0] iCmd_in = '0;
   logic        iAck_in = 1'b0;
   logic        iCmd_pin = 1'b1;
   logic        oCmd_pin, oCmd_oe, oStrobe_out, oAck_out, oTimeout, oBusy, oCrc_error;
   logic [47:0] oResponse;

   localparam logic [47:0] CMD0_IN  = 48'h40000000_00FF;
   localparam logic [47:0] CMD0_TX  = 48'h40000000_0095;
   localparam logic [47:0] CMD8_IN  = 48'h48000001_AAFF;
   localparam logic [47:0] CMD8_TX  = 48'h48000001_AA87;
   localparam logic [47:0] R7_OK    = 48'h08000001_AA13;
   localparam logic [47:0] R7_BAD   = 48'h08000001_AA11;

   int n_tests = 0;
   int n_fail  = 0;

   sd_cmd_phy dut (
      .iClock_host(clk), .iReset(iReset), .iBit_en(iBit_en), .iStrobe_in(iStrobe_in),
      .iCmd_in(iCmd_in), .iAck_in(iAck_in), .iCmd_pin(iCmd_pin), .oCmd_pin(oCmd_pin),
      .oCmd_oe(oCmd_oe), .oStrobe_out(oStrobe_out), .oAck_out(oAck_out),
      .oResponse(oResponse), .oTimeout(oTimeout), .oBusy(oBusy), .oCrc_error(oCrc_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Bus monitor: captures one pin bit per enabled tick while the driver stays enabled
   logic [47:0] cap = '0;
   int cap_n = 0, ack_cnt = 0, tmo_cnt = 0;
   always @(posedge clk) begin : mon
      logic e, o;
      e = iBit_en;
      o = oCmd_oe;
      #1;
      if (oAck_out) begin ack_cnt++; cap_n = 0; cap = '0; end
      if (oTimeout) tmo_cnt++;
      if (e && o && oCmd_oe) begin cap = {cap[46:0], oCmd_pin}; cap_n++; end
   end

   bit div = 1'b0;
   int ph  = 0;
   always @(negedge clk) begin
      if (div) begin iBit_en = (ph % 4 == 0); ph = ph + 1; end
      else iBit_en = 1'b1;
   end

   task automatic send(input logic [47:0] c);
      @(negedge clk);
      iCmd_in = c;
      iStrobe_in = 1'b1;
      @(negedge clk);
      iStrobe_in = 1'b0;
   endtask

   task automatic wait_caps(input int n, input int budget);
      int k = 0;
      while (cap_n < n && k < budget) begin @(negedge clk); k++; end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (oBusy && k < budget) begin @(negedge clk); k++; end
   endtask

   task automatic respond(input logic [47:0] r, input int idle);
      for (int i = 0; i < idle; i++) begin iCmd_pin = 1'b1; @(negedge clk); end
      for (int b = 47; b >= 0; b--) begin iCmd_pin = r[b]; @(negedge clk); end
      iCmd_pin = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a0;
      repeat (3) @(negedge clk);
      chk("rst_pin", 48'(oCmd_pin), 48'd1);
      chk("rst_oe", 48'(oCmd_oe), 48'd0);
      chk("rst_strobe", 48'(oStrobe_out), 48'd0);
      chk("rst_ack", 48'(oAck_out), 48'd0);
      chk("rst_resp", oResponse, 48'd0);
      chk("rst_tmo", 48'(oTimeout), 48'd0);
      chk("rst_busy", 48'(oBusy), 48'd0);
      chk("rst_crcerr", 48'(oCrc_error), 48'd0);
      iReset = 1'b0;
      @(negedge clk);

      // CMD0, no card answer -> timeout
      send(CMD0_IN);
      chk("cmd0_busy", 48'(oBusy), 48'd1);
      wait_caps(48, 200);
      chk("cmd0_nbits", 48'(cap_n), 48'd48);
      chk("cmd0_frame", cap, CMD0_TX);
      chk("cmd0_ack", 48'(ack_cnt), 48'd1);
      chk("cmd0_oe_last", 48'(oCmd_oe), 48'd1);
      @(negedge clk);
      chk("cmd0_oe_off", 48'(oCmd_oe), 48'd0);
      chk("cmd0_pin_idle", 48'(oCmd_pin), 48'd1);
      n = 0;
      while (!oTimeout && n < 200) begin @(negedge clk); n++; end
      chk("tmo_ticks", 48'(n), 48'd64);
      @(negedge clk);
      chk("tmo_pulses", 48'(tmo_cnt), 48'd1);
      chk("tmo_no_strobe", 48'(oStrobe_out), 48'd0);
      chk("tmo_idle", 48'(oBusy), 48'd0);

      // CMD8 with R7 response after 5 idle bits
      send(CMD8_IN);
      wait_caps(48, 200);
      chk("cmd8_frame", cap, CMD8_TX);
      @(negedge clk);
      respond(R7_OK, 5);
      chk("r7_strobe", 48'(oStrobe_out), 48'd1);
      chk("r7_resp", oResponse, R7_OK);
      chk("r7_crcerr", 48'(oCrc_error), 48'd0);
      repeat (3) @(negedge clk);
      chk("r7_hold_strobe", 48'(oStrobe_out), 48'd1);
      chk("r7_hold_busy", 48'(oBusy), 48'd1);
      iAck_in = 1'b1;
      @(negedge clk);
      iAck_in = 1'b0;
      chk("r7_ack_strobe", 48'(oStrobe_out), 48'd0);
      chk("r7_ack_idle", 48'(oBusy), 48'd0);
      chk("r7_resp_kept", oResponse, R7_OK);
      chk("r7_tmo_none", 48'(tmo_cnt), 48'd1);

      // Strobe level held high: one accept only
      a0 = ack_cnt;
      @(negedge clk);
      iCmd_in = CMD0_IN;
      iStrobe_in = 1'b1;
      @(negedge clk);
      wait_idle(400);
      repeat (5) @(negedge clk);
      chk("held_one_accept", 48'(ack_cnt - a0), 48'd1);
      iStrobe_in = 1'b0;
      @(negedge clk);
      iStrobe_in = 1'b1;
      @(negedge clk);
      chk("reraise_accept", 48'(ack_cnt - a0), 48'd2);
      iStrobe_in = 1'b0;
      @(negedge clk);
      iStrobe_in = 1'b1;
      @(negedge clk);
      iStrobe_in = 1'b0;
      chk("busy_edge_ignored", 48'(ack_cnt - a0), 48'd2);

      // Reset at bit 20 of SEND
      wait_caps(20, 200);
      iReset = 1'b1;
      @(negedge clk);
      chk("abort_oe", 48'(oCmd_oe), 48'd0);
      chk("abort_pin", 48'(oCmd_pin), 48'd1);
      chk("abort_busy", 48'(oBusy), 48'd0);
      iReset = 1'b0;
      send(CMD8_IN);
      wait_caps(48, 200);
      chk("post_rst_frame", cap, CMD8_TX);
      wait_idle(400);

      // Bit enable every 4th cycle
      div = 1'b1;
      send(CMD0_IN);
      wait_caps(1, 50);
      n = 0;
      while (oCmd_oe && n < 400) begin @(negedge clk); n++; end
      chk("slow_duration", 48'(n), 48'd192);
      chk("slow_frame", cap, CMD0_TX);
      div = 1'b0;
      wait_idle(600);
      chk("slow_idle", 48'(oBusy), 48'd0);

      // Corrupted response CRC
      send(CMD8_IN);
      wait_caps(48, 200);
      @(negedge clk);
      respond(R7_BAD, 2);
      chk("bad_strobe", 48'(oStrobe_out), 48'd1);
      chk("bad_resp", oResponse, R7_BAD);
`ifdef SD_CMD_RESP_CRC_CHECK_EN
      chk("bad_crcerr", 48'(oCrc_error), 48'd1);
`else
      chk("bad_crcerr", 48'(oCrc_error), 48'd0);
`endif
      iAck_in = 1'b1;
      @(negedge clk);
      iAck_in = 1'b0;
      chk("bad_ack_idle", 48'(oBusy), 48'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
